// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges EX redirect, multi-cycle EX, ID load-use and bus stall
// requests into PC / IF-ID / ID-EX hold, flush and redirect controls.
module pipe_ctrl #(
  parameter int MULTI_CYC = 4,
  parameter int CNT_W     = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        mc_start_i,
  input  logic        load_use_i,
  input  logic        bus_stall_i,
  output logic        pc_jump_en_o,
  output logic [31:0] pc_jump_addr_o,
  output logic        pc_hold_o,
  output logic        if_id_hold_o,
  output logic        if_id_flush_o,
  output logic        id_ex_hold_o,
  output logic        id_ex_flush_o,
  output logic        mc_done_o,
  output logic [31:0] stall_cycles_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MC_BUSY  = 2'd1,
    JMP_PEND = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_next_cnt;
  logic [31:0]        r_pend_addr;
  logic [31:0]        w_next_pend_addr;
  logic [31:0]        r_stall_cycles;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state     = r_state;
    w_next_cnt       = r_cnt;
    w_next_pend_addr = r_pend_addr;
    pc_jump_en_o     = 1'b0;
    pc_jump_addr_o   = 32'd0;
    pc_hold_o        = 1'b0;
    if_id_hold_o     = 1'b0;
    if_id_flush_o    = 1'b0;
    id_ex_hold_o     = 1'b0;
    id_ex_flush_o    = 1'b0;
    mc_done_o        = 1'b0;

    case (r_state)
      RUN: begin
        if (bus_stall_i) begin
          pc_hold_o    = 1'b1;
          if_id_hold_o = 1'b1;
          id_ex_hold_o = 1'b1;
          // A redirect seen while the bus is stalled is parked until the stall clears.
          if (jump_en_i) begin
            w_next_pend_addr = jump_addr_i;
            w_next_state     = JMP_PEND;
          end
        end else if (jump_en_i) begin
          pc_jump_en_o   = 1'b1;
          pc_jump_addr_o = jump_addr_i;
          if_id_flush_o  = 1'b1;
          id_ex_flush_o  = 1'b1;
        end else if (mc_start_i) begin
          pc_hold_o    = 1'b1;
          if_id_hold_o = 1'b1;
          id_ex_hold_o = 1'b1;
          w_next_cnt   = CNT_W'(MULTI_CYC - 2);
          w_next_state = MC_BUSY;
        end else if (load_use_i) begin
          pc_hold_o     = 1'b1;
          if_id_hold_o  = 1'b1;
          id_ex_flush_o = 1'b1;
        end
      end

      MC_BUSY: begin
        pc_hold_o    = 1'b1;
        if_id_hold_o = 1'b1;
        id_ex_hold_o = 1'b1;
        if (!bus_stall_i) begin
          if (r_cnt == '0) begin
            mc_done_o    = 1'b1;
            w_next_state = RUN;
          end else begin
            w_next_cnt = r_cnt - 1'b1;
          end
        end
      end

      JMP_PEND: begin
        pc_jump_addr_o = r_pend_addr;
        if (bus_stall_i) begin
          pc_hold_o    = 1'b1;
          if_id_hold_o = 1'b1;
          id_ex_hold_o = 1'b1;
        end else begin
          pc_jump_en_o  = 1'b1;
          if_id_flush_o = 1'b1;
          id_ex_flush_o = 1'b1;
          w_next_state  = RUN;
        end
      end

      default: w_next_state = RUN;
    endcase

    if (rst) begin
      pc_jump_en_o   = 1'b0;
      pc_jump_addr_o = 32'd0;
      pc_hold_o      = 1'b0;
      if_id_hold_o   = 1'b0;
      if_id_flush_o  = 1'b0;
      id_ex_hold_o   = 1'b0;
      id_ex_flush_o  = 1'b0;
      mc_done_o      = 1'b0;
    end
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= RUN;
      r_cnt          <= '0;
      r_pend_addr    <= 32'd0;
      r_stall_cycles <= 32'd0;
    end else begin
      r_state     <= w_next_state;
      r_cnt       <= w_next_cnt;
      r_pend_addr <= w_next_pend_addr;
      if (pc_hold_o)
        r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles_o = rst ? 32'd0 : r_stall_cycles;

`ifndef SYNTHESIS
  a_no_mc_with_jump: assert property (@(posedge clk) disable iff (rst)
    !(mc_start_i && jump_en_i));
`endif

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline sequencer for the 5-stage RV32I core. It collects redirect and stall requests from EX, ID and the memory bus. It drives the PC redirect and the hold/flush controls of the PC, IF/ID and ID/EX registers. It owns a multi-cycle EX-operation timer and a pending-jump latch, so that a redirect arriving during a bus stall is never lost.

Parameters:
MULTI_CYC, 4, total cycles the pipe is held for one multi-cycle EX op, start cycle included; legal range is 2 or more.
CNT_W, 6, width of the internal multi-cycle down-counter; must satisfy 2^CNT_W > MULTI_CYC.

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
jump_en_i  in  1  EX branch/jump taken (from ex jump_en2ctrl)
jump_addr_i  in  32  EX target address (from ex jump_addr2ctrl)
mc_start_i  in  1  EX begins a multi-cycle op (from ex hold2ctrl); one-cycle pulse
load_use_i  in  1  ID load-use hazard detected
bus_stall_i  in  1  instruction/data bus not ready
pc_jump_en_o  out  1  PC loads pc_jump_addr_o this cycle
pc_jump_addr_o  out  32  redirect target
pc_hold_o  out  1  PC register holds
if_id_hold_o  out  1  IF/ID register holds
if_id_flush_o  out  1  IF/ID register loads NOP
id_ex_hold_o  out  1  ID/EX register holds
id_ex_flush_o  out  1  ID/EX register loads NOP
mc_done_o  out  1  final cycle of the multi-cycle op; EX writes its result
stall_cycles_o  out  32  count of cycles with pc_hold_o=1

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset:
  - State goes to RUN; cnt, pend_addr and stall_cycles_o clear to 0.
  - While rst=1, every output is 0.
  - A reset asserted during MC_BUSY or JMP_PEND discards the op or pending jump with no done/jump pulse.
- Output timing: all control outputs are combinational from current state plus inputs, giving zero latency. Only state, cnt, pend_addr and stall_cycles_o are registered.
- State RUN, priority from highest to lowest:
  1. bus_stall_i=1: pc/if_id/id_ex holds=1, flushes=0. If jump_en_i=1, latch pend_addr<=jump_addr_i and go to JMP_PEND. mc_start_i is ignored (EX re-presents it after the stall).
  2. jump_en_i=1: pc_jump_en_o=1, pc_jump_addr_o=jump_addr_i, if_id_flush_o=1, id_ex_flush_o=1, holds=0. mc_start_i and load_use_i are ignored that cycle.
  3. mc_start_i=1: pc/if_id/id_ex holds=1, cnt<=MULTI_CYC-2, go to MC_BUSY.
  4. load_use_i=1: pc_hold_o=1, if_id_hold_o=1, id_ex_flush_o=1 (bubble), id_ex_hold_o=0.
  5. Otherwise all outputs are 0.
- State MC_BUSY:
  - pc/if_id/id_ex holds=1; jump_en_i and load_use_i are ignored.
  - bus_stall_i=1 freezes cnt, with no done pulse.
  - Else if cnt==0: mc_done_o=1 and go to RUN next cycle.
  - Else cnt<=cnt-1.
  - Net effect: holds are asserted for exactly MULTI_CYC cycles when there is no bus stall, with mc_done_o on the last of them.
- State JMP_PEND:
  - While bus_stall_i=1: holds=1, pc_jump_addr_o=pend_addr. Later jump_en_i pulses are ignored, because EX is held.
  - When bus_stall_i=0: pc_jump_en_o=1, pc_jump_addr_o=pend_addr, both flushes=1, holds=0, go to RUN.
- pc_jump_addr_o is 0 whenever pc_jump_en_o=0, except in JMP_PEND, where it shows pend_addr.
- Flush and hold on the same register are never both 1; flush wins.
- stall_cycles_o increments by 1 on every cycle pc_hold_o=1 and rst=0. It wraps 0xFFFFFFFF to 0.
- Illegal inputs: mc_start_i and jump_en_i together is flagged by a simulation-only assertion; the jump still wins.

Test Plan:
- Plain jump: RUN, jump_en_i=1, jump_addr_i=0x0000_0100 for 1 cycle -> pc_jump_en_o=1, addr 0x100, both flushes=1 that same cycle, all holds=0; the next cycle is all 0.
- Multi-cycle op, MULTI_CYC=4: mc_start_i pulse at T -> holds=1 on T..T+3, mc_done_o=1 only on T+3, holds=0 on T+4, stall_cycles_o +4. Then inject bus_stall_i at T+1 for 2 cycles -> done moves to T+5.
- Jump under stall: bus_stall_i=1, jump_en_i=1, addr 0x0000_2000, with the stall held 3 cycles -> holds=1 and no jump for 3 cycles; in the cycle the stall drops, pc_jump_en_o=1, addr 0x2000, both flushes=1.
- Load-use vs jump: load_use_i=1 alone -> pc_hold_o=1, if_id_hold_o=1, id_ex_flush_o=1. load_use_i=1 with jump_en_i=1 (addr 0x40) -> jump only, no holds.
- Reset mid-op: mc_start_i at T, rst=1 at T+1 for 1 cycle -> all outputs 0 at T+1. Then T+2 is in RUN with no mc_done_o, and stall_cycles_o=0.
- Counter wrap: preload stall_cycles_o to 0xFFFF_FFFF via force, hold 1 cycle -> reads 0x0000_0000.
